// File: rtl/freelist_ckpt_if.sv
// -----------------------------------------------------------------------------
// freelist_ckpt_if
//   Rename/commit-side bundle for the checkpointed physical-register free list.
//   master : rename + commit + branch unit (drives requests, releases, checkpoints)
//   slave  : freelist_ckpt (drives grants, allocatable, free_count)
//
//   prf_req        per-slot allocation request
//   prf_out        granted PRF per slot, packed slot0 in the low IDX bits
//   allocatable    every requested slot can be granted this cycle
//   release_valid  per-port release strobe
//   release_prf    PRF per release port, packed like prf_out
//   check/check_idx      take checkpoint
//   recover/recover_idx  restore from checkpoint
//   free_count     registered number of free PRFs
//   double_free    sticky release-error flag, present only with FREELIST_CHECK_EN
// -----------------------------------------------------------------------------
interface freelist_ckpt_if #(
    parameter int RENAME_WIDTH = 3,
    parameter int PRF_NUM      = 64,
    parameter int CP_NUM       = 4
);
    localparam int IDX = $clog2(PRF_NUM);
    localparam int CPI = (CP_NUM > 1) ? $clog2(CP_NUM) : 1;

    logic [RENAME_WIDTH-1:0]     prf_req;
    logic [RENAME_WIDTH*IDX-1:0] prf_out;
    logic                        allocatable;
    logic [RENAME_WIDTH-1:0]     release_valid;
    logic [RENAME_WIDTH*IDX-1:0] release_prf;
    logic                        check;
    logic [CPI-1:0]              check_idx;
    logic                        recover;
    logic [CPI-1:0]              recover_idx;
    logic [IDX:0]                free_count;

`ifdef FREELIST_CHECK_EN
    logic                        double_free;

    modport master (
        output prf_req, release_valid, release_prf, check, check_idx, recover, recover_idx,
        input  prf_out, allocatable, free_count, double_free
    );
    modport slave (
        input  prf_req, release_valid, release_prf, check, check_idx, recover, recover_idx,
        output prf_out, allocatable, free_count, double_free
    );
`else
    modport master (
        output prf_req, release_valid, release_prf, check, check_idx, recover, recover_idx,
        input  prf_out, allocatable, free_count
    );
    modport slave (
        input  prf_req, release_valid, release_prf, check, check_idx, recover, recover_idx,
        output prf_out, allocatable, free_count
    );
`endif
endinterface

// File: rtl/freelist_ckpt.sv
// -----------------------------------------------------------------------------
// freelist_ckpt
//   Bitmap physical-register free list for the rename stage. Grants up to
//   RENAME_WIDTH PRFs per cycle (lowest free indices, ascending slot order),
//   accepts up to RENAME_WIDTH commit releases per cycle, and keeps CP_NUM
//   branch checkpoints whose masks collect wrong-path grants so a recover can
//   hand them back in one cycle.
//
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   fl       freelist_ckpt_if.slave (see the interface header for the signals)
//
//   Optional feature macro: FREELIST_CHECK_EN -- adds the sticky double_free
//   flag and its detection logic.
// -----------------------------------------------------------------------------
module freelist_ckpt #(
    parameter int RENAME_WIDTH = 3,
    parameter int PRF_NUM      = 64,
    parameter int ARCH_REGS    = 32,
    parameter int CP_NUM       = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    freelist_ckpt_if.slave fl
);
    localparam int IDX = $clog2(PRF_NUM);
    localparam int CPI = (CP_NUM > 1) ? $clog2(CP_NUM) : 1;

    // PRFs 0..ARCH_REGS-1 carry the reset architectural mapping.
    localparam logic [PRF_NUM-1:0] RESET_FREE = {{(PRF_NUM-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
    localparam logic [IDX:0]       RESET_CNT  = (IDX+1)'(PRF_NUM - ARCH_REGS);

    function automatic logic [IDX:0] count_ones(input logic [PRF_NUM-1:0] v);
        logic [IDX:0] n;
        n = '0;
        for (int i = 0; i < PRF_NUM; i++) n = n + (IDX+1)'(v[i]);
        return n;
    endfunction

    // State
    logic [PRF_NUM-1:0] free_q;
    logic [IDX:0]       free_count_q;
    logic [CP_NUM-1:0]  ckpt_valid_q;
    logic [PRF_NUM-1:0] ckpt_mask_q [CP_NUM];

    // Next state / combinational results
    logic [PRF_NUM-1:0]          free_n;
    logic [IDX:0]                free_count_n;
    logic [CP_NUM-1:0]           ckpt_valid_n;
    logic [PRF_NUM-1:0]          ckpt_mask_n [CP_NUM];
    logic [PRF_NUM-1:0]          avail;
    logic [PRF_NUM-1:0]          grant_mask;
    logic [PRF_NUM-1:0]          grant_applied;
    logic [PRF_NUM-1:0]          rel_mask;
    logic [RENAME_WIDTH*IDX-1:0] prf_out_d;
    logic [IDX:0]                req_cnt;
    logic [IDX-1:0]              rp;
    logic                        found;
    logic                        alloc_ok;
    logic                        grant_en;

    // Slot-ordered lowest-free search over the current bitmap. Each slot takes
    // the lowest bit still available after the slots below it have claimed theirs.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves a value held over from the previous evaluation (no latch).
        avail      = free_q;
        grant_mask = '0;
        prf_out_d  = '0;
        found      = 1'b0;
        for (int s = 0; s < RENAME_WIDTH; s++) begin
            found = 1'b0;
            if (fl.prf_req[s]) begin
                for (int i = 0; i < PRF_NUM; i++) begin
                    if (!found && avail[i]) begin
                        found                   = 1'b1;
                        avail[i]                = 1'b0;
                        grant_mask[i]           = 1'b1;
                        prf_out_d[s*IDX +: IDX] = IDX'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int s = 0; s < RENAME_WIDTH; s++) req_cnt = req_cnt + (IDX+1)'(fl.prf_req[s]);
    end

    // All-or-nothing: a short free list grants nothing rather than a subset.
    assign alloc_ok      = (free_count_q >= req_cnt);
    assign grant_en      = alloc_ok && (|fl.prf_req) && !fl.recover;
    assign grant_applied = grant_en ? grant_mask : '0;

    // Release decode. PRF 0 is hard-wired busy, so its releases are dropped.
`ifdef FREELIST_CHECK_EN
    logic dup_release;
    logic double_free_q;
`endif
    always_comb begin
        rel_mask = '0;
        rp       = '0;
`ifdef FREELIST_CHECK_EN
        dup_release = 1'b0;
`endif
        for (int p = 0; p < RENAME_WIDTH; p++) begin
            rp = fl.release_prf[p*IDX +: IDX];
            if (fl.release_valid[p] && (rp != '0)) begin
`ifdef FREELIST_CHECK_EN
                // Already free, or already released by a lower port this cycle.
                if (free_q[rp] || rel_mask[rp]) dup_release = 1'b1;
`endif
                rel_mask[rp] = 1'b1;
            end
        end
    end

    // Bitmap and checkpoint next state.
    always_comb begin
        free_n = free_q & ~grant_applied;
        if (fl.recover && ckpt_valid_q[fl.recover_idx]) free_n = free_n | ckpt_mask_q[fl.recover_idx];
        free_n    = free_n | rel_mask;
        free_n[0] = 1'b0;
        free_count_n = count_ones(free_n);

        for (int c = 0; c < CP_NUM; c++) begin
            ckpt_valid_n[c] = ckpt_valid_q[c];
            ckpt_mask_n[c]  = ckpt_mask_q[c];
            if (fl.recover) begin
                // Recover flushes every checkpoint and overrides a same-cycle check.
                ckpt_valid_n[c] = 1'b0;
                ckpt_mask_n[c]  = '0;
            end else if (fl.check && (fl.check_idx == CPI'(c))) begin
                // Same-cycle grants belong to the path older than the branch.
                ckpt_valid_n[c] = 1'b1;
                ckpt_mask_n[c]  = '0;
            end else if (ckpt_valid_q[c]) begin
                // Committed releases leave the mask so a recover cannot re-free them.
                ckpt_mask_n[c] = (ckpt_mask_q[c] | grant_applied) & ~rel_mask;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            free_q       <= RESET_FREE;
            free_count_q <= RESET_CNT;
            ckpt_valid_q <= '0;
            // NOTE: the mask array is reset as well, not just the valid bits,
            // so a post-reset recover can never see stale contents.
            for (int c = 0; c < CP_NUM; c++) ckpt_mask_q[c] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the pre-edge values computed above.
            free_q       <= free_n;
            free_count_q <= free_count_n;
            ckpt_valid_q <= ckpt_valid_n;
            for (int c = 0; c < CP_NUM; c++) ckpt_mask_q[c] <= ckpt_mask_n[c];
        end
    end

`ifdef FREELIST_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) double_free_q <= 1'b0;
        else          double_free_q <= double_free_q | dup_release;
    end
    assign fl.double_free = double_free_q;
`endif

    assign fl.prf_out     = prf_out_d;
    assign fl.allocatable = alloc_ok;
    assign fl.free_count  = free_count_q;

endmodule

// File: tb/tb_freelist_ckpt.sv
// -----------------------------------------------------------------------------
// tb_freelist_ckpt
//   Table of per-cycle vectors for freelist_ckpt (default parameters), with
//   expected outputs queued on drive and compared before the next rising edge,
//   followed by hand-written double-release and mid-burst reset sequences.
// -----------------------------------------------------------------------------
module tb_freelist_ckpt;
    localparam int RW  = 3;
    localparam int PN  = 64;
    localparam int AR  = 32;
    localparam int CN  = 4;
    localparam int IDX = 6;

    logic clock;
    logic reset_n;

    freelist_ckpt_if #(.RENAME_WIDTH(RW), .PRF_NUM(PN), .CP_NUM(CN)) fl ();

    freelist_ckpt #(
        .RENAME_WIDTH(RW),
        .PRF_NUM     (PN),
        .ARCH_REGS   (AR),
        .CP_NUM      (CN)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .fl     (fl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  rv;
        logic [17:0] rel;
        logic        chk;
        logic [1:0]  chk_idx;
        logic        rec;
        logic [1:0]  rec_idx;
        logic [17:0] exp_out;
        logic        chk_out;
        logic        exp_alloc;
        logic [6:0]  exp_fc;
    } vec_t;

    typedef struct {
        logic [17:0] prf_out;
        logic        chk_out;
        logic        alloc;
        logic [6:0]  fc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] rv,
                                input int r0, input int r1, input int r2,
                                input logic chk, input int ci, input logic rec, input int ri,
                                input int o0, input int o1, input int o2,
                                input logic chk_out, input logic alloc, input int fc);
        vec_t v;
        v.req       = req;
        v.rv        = rv;
        v.rel       = {6'(r2), 6'(r1), 6'(r0)};
        v.chk       = chk;
        v.chk_idx   = 2'(ci);
        v.rec       = rec;
        v.rec_idx   = 2'(ri);
        v.exp_out   = {6'(o2), 6'(o1), 6'(o0)};
        v.chk_out   = chk_out;
        v.exp_alloc = alloc;
        v.exp_fc    = 7'(fc);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fl.prf_req       = v.req;
        fl.release_valid = v.rv;
        fl.release_prf   = v.rel;
        fl.check         = v.chk;
        fl.check_idx     = v.chk_idx;
        fl.recover       = v.rec;
        fl.recover_idx   = v.rec_idx;
    endtask

    task automatic idle();
        fl.prf_req       = '0;
        fl.release_valid = '0;
        fl.release_prf   = '0;
        fl.check         = 1'b0;
        fl.check_idx     = '0;
        fl.recover       = 1'b0;
        fl.recover_idx   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [17:0] po;

        //          req     rv      r0 r1 r2  chk ci rec ri  o0 o1 o2  co al fc
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 32)); // reset state
        vecs.push_back(mk(3'b101, 3'b000,  0, 0, 0, 0, 0, 0, 0, 32, 0,33, 1, 1, 32)); // sparse request
        vecs.push_back(mk(3'b001, 3'b001, 32, 0, 0, 0, 0, 0, 0, 34, 0, 0, 1, 1, 30)); // release not regranted
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 1, 1, 0, 0, 32, 0, 0, 1, 1, 30)); // check 1, grant excluded
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 35,36,37, 1, 1, 29));
        vecs.push_back(mk(3'b111, 3'b001, 36, 0, 0, 0, 0, 0, 0, 38,39,40, 1, 1, 26)); // release leaves mask
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 1, 1, 36,41,42, 1, 1, 24)); // recover 1, no grant
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 35, 0, 0, 1, 1, 29)); // restored
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 28)); // recover invalid slot
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 36, 0, 0, 1, 1, 28));
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 1, 2, 1, 0,  0, 0, 0, 1, 1, 27)); // check+recover
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 37,38,39, 1, 1, 27));
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 0, 0, 1, 2,  0, 0, 0, 1, 1, 24)); // slot 2 never taken
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 40, 0, 0, 1, 1, 24));
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 23)); // check 0
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 41, 0, 0, 1, 1, 23));
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 1, 0, 0, 0, 42, 0, 0, 1, 1, 22)); // re-check 0
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 43, 0, 0, 1, 1, 21));
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 1, 0, 44, 0, 0, 1, 1, 20)); // recover 0
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 43, 0, 0, 1, 1, 21)); // only 43 back
        vecs.push_back(mk(3'b000, 3'b100,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 20)); // release PRF 0
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0, 44, 0, 0, 1, 1, 20));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 45,46,47, 1, 1, 19));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 48,49,50, 1, 1, 16));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 51,52,53, 1, 1, 13));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 54,55,56, 1, 1, 10));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 57,58,59, 1, 1,  7));
        vecs.push_back(mk(3'b011, 3'b000,  0, 0, 0, 0, 0, 0, 0, 60,61, 0, 1, 1,  4));
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2)); // short: no grant
        vecs.push_back(mk(3'b111, 3'b001, 45, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2)); // bitmap held
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 45,62,63, 1, 1,  3));
        vecs.push_back(mk(3'b000, 3'b000,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  0)); // empty, no request
        vecs.push_back(mk(3'b001, 3'b000,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0)); // empty, request
        vecs.push_back(mk(3'b000, 3'b111, 50,40,60, 0, 0, 0, 0,  0, 0, 0, 1, 1,  0)); // 3-port release
        vecs.push_back(mk(3'b111, 3'b000,  0, 0, 0, 0, 0, 0, 0, 40,50,60, 1, 1,  3));

        idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            sb.push_back('{prf_out: vecs[i].exp_out, chk_out: vecs[i].chk_out,
                           alloc: vecs[i].exp_alloc, fc: vecs[i].exp_fc});
            #2;
            e = sb.pop_front();
            if (e.chk_out) check($sformatf("v%0d prf_out", i), 64'(fl.prf_out), 64'(e.prf_out));
            check($sformatf("v%0d allocatable", i), 64'(fl.allocatable), 64'(e.alloc));
            check($sformatf("v%0d free_count", i), 64'(fl.free_count), 64'(e.fc));
        end

`ifdef FREELIST_CHECK_EN
        // List is empty here; PRF 40 released on ports 0 and 1 together.
        @(negedge clock);
        idle();
        fl.release_valid = 3'b011;
        fl.release_prf   = {6'd0, 6'd40, 6'd40};
        #2;
        check("dup double_free before edge", 64'(fl.double_free), 64'd0);
        @(negedge clock);
        idle();
        fl.prf_req = 3'b001;
        #2;
        check("dup double_free", 64'(fl.double_free), 64'd1);
        check("dup free_count", 64'(fl.free_count), 64'd1);
        check("dup prf_out", 64'(fl.prf_out), 64'd40);
`endif

        // Mid-burst asynchronous reset.
        @(negedge clock);
        idle();
        fl.release_valid = 3'b111;
        fl.release_prf   = {6'd35, 6'd34, 6'd33};
        @(negedge clock);
        idle();
        fl.prf_req = 3'b111;
        #2;
        po = {6'd35, 6'd34, 6'd33};
        check("burst prf_out", 64'(fl.prf_out), 64'(po));
        check("burst free_count", 64'(fl.free_count), 64'd3);
        #1;
        reset_n = 1'b0;
        #1;
        po = {6'd34, 6'd33, 6'd32};
        check("async rst free_count", 64'(fl.free_count), 64'd32);
        check("async rst prf_out", 64'(fl.prf_out), 64'(po));
        check("async rst allocatable", 64'(fl.allocatable), 64'd1);
`ifdef FREELIST_CHECK_EN
        check("async rst double_free", 64'(fl.double_free), 64'd0);
`endif
        @(negedge clock);
        #2;
        check("held rst free_count", 64'(fl.free_count), 64'd32);
        idle();
        reset_n = 1'b1;
        @(negedge clock);
        fl.prf_req = 3'b001;
        #2;
        check("post rst free_count", 64'(fl.free_count), 64'd32);
        check("post rst prf_out", 64'(fl.prf_out), 64'd32);
        @(negedge clock);
        idle();
        #2;
        check("post rst grant count", 64'(fl.free_count), 64'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
